// File: rtl/core5_pkg.sv
// Shared definitions for the switches-PIO arbiter: FSM state encoding and
// default bus geometry.
package core5_pkg;

    localparam int N_REQ_DEF  = 5;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/core5_rr_picker.sv
// Combinational round-robin picker: the first requester at or after
// (last_grant+1) mod N_REQ, scanning upward with wrap, wins.
module core5_rr_picker
    import core5_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester is assigned last and wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(last_grant_i) + i) % N_REQ);
            if (req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core5_switch_arbiter.sv
// Arbitrates N_REQ core read ports onto one switches PIO with a fixed
// IDLE -> ADDR -> DATA sequence, one read per three cycles.
module core5_switch_arbiter
    import core5_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ*ADDR_W-1:0] req_address,
    output logic [N_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]       req_readdata,
    output logic [ADDR_W-1:0]       pio_address,
    input  logic [DATA_W-1:0]       pio_readdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] pio_address_q, pio_address_d;

    logic [IDX_W-1:0] pick;
    logic             pick_valid;

    core5_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i        (req_read),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        pio_address_d = pio_address_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d       = ADDR;
                    grant_d       = pick;
                    last_grant_d  = pick;
                    pio_address_d = req_address[int'(pick)*ADDR_W +: ADDR_W];
                end
            end
            ADDR:    state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDX_W'(N_REQ - 1);
            pio_address_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            pio_address_q <= pio_address_d;
        end
    end

    // Only the granted port sees its stall drop, and only in the DATA cycle.
    always_comb begin
        req_waitrequest = '1;
        if (state_q == DATA) begin
            req_waitrequest[grant_q] = 1'b0;
        end
    end

    assign req_readdata = pio_readdata;
    assign pio_address  = pio_address_q;

endmodule

// File: tb/tb_core5_switch_arbiter.sv
// Directed bench for core5_switch_arbiter with a one-cycle-latency PIO model.
module tb_core5_switch_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam logic [DW-1:0] SW_VAL = 32'h0002A5C3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_read;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_waitrequest;
    logic [DW-1:0]   req_readdata;
    logic [AW-1:0]   pio_address;
    logic [DW-1:0]   pio_readdata;

    int n_vec = 0;
    int n_err = 0;

    core5_switch_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_read        (req_read),
        .req_address     (req_address),
        .req_waitrequest (req_waitrequest),
        .req_readdata    (req_readdata),
        .pio_address     (pio_address),
        .pio_readdata    (pio_readdata)
    );

    always #5 clk = ~clk;

    // Switches PIO: word 0 holds the switch value, every other word reads zero.
    always @(posedge clk) begin
        pio_readdata <= (pio_address == '0) ? SW_VAL : '0;
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        req_read = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Drives one arbitration round starting at an IDLE negedge and captures what the
    // ports show in the IDLE, ADDR and DATA cycles; ends at the next IDLE negedge.
    task automatic run_read(input logic [N-1:0] req, input logic [N-1:0] req_mid,
                            input logic [N-1:0] req_after,
                            output logic [N-1:0] wr_idle, output logic [N-1:0] wr_addr,
                            output logic [AW-1:0] pa_addr, output logic [N-1:0] wr_data,
                            output logic [DW-1:0] rd_data);
        req_read = req;
        wr_idle  = req_waitrequest;
        @(negedge clk);
        wr_addr  = req_waitrequest;
        pa_addr  = pio_address;
        req_read = req_mid;
        @(negedge clk);
        wr_data  = req_waitrequest;
        rd_data  = req_readdata;
        req_read = req_after;
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_address = '0;
        do_reset();
        n_vec++;
        if (req_waitrequest !== 5'h1F) begin
            n_err++;
            $display("FAIL reset_wr: got %b expected %b", req_waitrequest, 5'h1F);
        end
        n_vec++;
        if (pio_address !== 2'd0) begin
            n_err++;
            $display("FAIL reset_pio_addr: got %0d expected 0", pio_address);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (req_waitrequest !== 5'h1F) begin
            n_err++;
            $display("FAIL idle_no_req_wr: got %b expected %b", req_waitrequest, 5'h1F);
        end
    endtask

    task automatic test_single_read();
        logic [N-1:0] wi, wa, wd;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd;
        req_address = '0;
        do_reset();
        reset_n = 1'b1;
        run_read(5'b00001, 5'b00001, 5'b00000, wi, wa, pa, wd, rd);
        n_vec++;
        if (wi !== 5'h1F || wa !== 5'h1F) begin
            n_err++;
            $display("FAIL single_early_wr: got %b/%b expected 11111/11111", wi, wa);
        end
        n_vec++;
        if (wd !== 5'b11110) begin
            n_err++;
            $display("FAIL single_data_wr: got %b expected 11110", wd);
        end
        n_vec++;
        if (rd !== SW_VAL) begin
            n_err++;
            $display("FAIL single_readdata: got %h expected %h", rd, SW_VAL);
        end
        n_vec++;
        if (req_waitrequest !== 5'h1F) begin
            n_err++;
            $display("FAIL single_after_wr: got %b expected 11111", req_waitrequest);
        end
    endtask

    task automatic test_all_five();
        logic [N-1:0] wi, wa, wd, exp_wd;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd;
        req_address = '0;
        do_reset();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_read(5'h1F, 5'h1F, 5'h1F, wi, wa, pa, wd, rd);
            exp_wd = ~(5'b00001 << (k % N));
            n_vec++;
            if (wd !== exp_wd || wi !== 5'h1F || wa !== 5'h1F) begin
                n_err++;
                $display("FAIL all5_grant%0d: got idle %b addr %b data %b expected data %b",
                         k, wi, wa, wd, exp_wd);
            end
        end
        req_read = '0;
    endtask

    task automatic test_contend();
        logic [N-1:0] wi, wa, wd;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd;
        req_address = '0;
        do_reset();
        reset_n = 1'b1;
        run_read(5'b00010, 5'b00010, 5'b00000, wi, wa, pa, wd, rd);
        n_vec++;
        if (wd !== 5'b11101) begin
            n_err++;
            $display("FAIL contend_setup: got %b expected 11101", wd);
        end
        run_read(5'b01010, 5'b01010, 5'b01010, wi, wa, pa, wd, rd);
        n_vec++;
        if (wd !== 5'b10111) begin
            n_err++;
            $display("FAIL contend_first: got %b expected 10111", wd);
        end
        run_read(5'b00010, 5'b00010, 5'b00000, wi, wa, pa, wd, rd);
        n_vec++;
        if (wd !== 5'b11101) begin
            n_err++;
            $display("FAIL contend_second: got %b expected 11101", wd);
        end
    endtask

    task automatic test_address_pass();
        logic [N-1:0] wi, wa, wd;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd;
        // Slices (4..0): 0, 3, 1, 3, 3 -- non-granted ports carry distracting addresses.
        req_address = 10'b00_11_01_11_11;
        do_reset();
        reset_n = 1'b1;
        run_read(5'b10100, 5'b10100, 5'b10000, wi, wa, pa, wd, rd);
        n_vec++;
        if (pa !== 2'd1 || wd !== 5'b11011) begin
            n_err++;
            $display("FAIL addr_req2: got pio_addr %0d wr %b expected 1 11011", pa, wd);
        end
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL addr_req2_data: got %h expected 00000000", rd);
        end
        run_read(5'b10000, 5'b10000, 5'b00000, wi, wa, pa, wd, rd);
        n_vec++;
        if (pa !== 2'd0 || wd !== 5'b01111 || rd !== SW_VAL) begin
            n_err++;
            $display("FAIL addr_req4: got pio_addr %0d wr %b data %h expected 0 01111 %h",
                     pa, wd, rd, SW_VAL);
        end
    endtask

    task automatic test_addr_hold();
        logic [N-1:0] wi, wa, wd;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd;
        req_address = 10'b00_00_00_00_10;
        do_reset();
        reset_n = 1'b1;
        run_read(5'b00001, 5'b00001, 5'b00000, wi, wa, pa, wd, rd);
        n_vec++;
        if (pa !== 2'd2 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL hold_read: got pio_addr %0d data %h expected 2 00000000", pa, rd);
        end
        req_address = 10'b01_01_01_01_01;
        repeat (3) @(negedge clk);
        n_vec++;
        if (pio_address !== 2'd2) begin
            n_err++;
            $display("FAIL hold_idle_addr: got %0d expected 2", pio_address);
        end
    endtask

    task automatic test_reset_abort();
        req_address = 10'b00_00_00_00_11;
        do_reset();
        reset_n  = 1'b1;
        req_read = 5'b00001;
        @(negedge clk);
        n_vec++;
        if (pio_address !== 2'd3 || req_waitrequest !== 5'h1F) begin
            n_err++;
            $display("FAIL abort_addr_cycle: got pio_addr %0d wr %b expected 3 11111",
                     pio_address, req_waitrequest);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_waitrequest !== 5'h1F || pio_address !== 2'd0) begin
            n_err++;
            $display("FAIL abort_no_pulse: got wr %b pio_addr %0d expected 11111 0",
                     req_waitrequest, pio_address);
        end
        reset_n  = 1'b1;
        req_read = 5'b00011;
        @(negedge clk);
        n_vec++;
        if (req_waitrequest !== 5'h1F || pio_address !== 2'd3) begin
            n_err++;
            $display("FAIL abort_regrant_addr: got wr %b pio_addr %0d expected 11111 3",
                     req_waitrequest, pio_address);
        end
        @(negedge clk);
        n_vec++;
        if (req_waitrequest !== 5'b11110) begin
            n_err++;
            $display("FAIL abort_regrant_data: got %b expected 11110", req_waitrequest);
        end
        req_read = '0;
        @(negedge clk);
    endtask

    task automatic test_drop_during_addr();
        logic [N-1:0] wi, wa, wd;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd;
        req_address = '0;
        do_reset();
        reset_n = 1'b1;
        run_read(5'b00101, 5'b00100, 5'b00100, wi, wa, pa, wd, rd);
        n_vec++;
        if (wd !== 5'b11110) begin
            n_err++;
            $display("FAIL drop_data_cycle: got %b expected 11110", wd);
        end
        n_vec++;
        if (req_waitrequest !== 5'h1F) begin
            n_err++;
            $display("FAIL drop_back_idle: got %b expected 11111", req_waitrequest);
        end
        run_read(5'b00100, 5'b00100, 5'b00000, wi, wa, pa, wd, rd);
        n_vec++;
        if (wd !== 5'b11011) begin
            n_err++;
            $display("FAIL drop_next_grant: got %b expected 11011", wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        req_read    = '0;
        req_address = '0;
        test_reset();
        test_single_read();
        test_all_five();
        test_contend();
        test_address_pass();
        test_addr_hold();
        test_reset_abort();
        test_drop_during_addr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core5_switch_arbiter.md
CORE5_SWITCH_ARBITER -- requirements
Module: core5_switch_arbiter

Interface
REQ-001 Parameter N_REQ, default 5, SHALL set the number of core requesters sharing the switches PIO.
REQ-002 Parameter DATA_W, default 32, SHALL set the readdata width.
REQ-003 Parameter ADDR_W, default 2, SHALL set the PIO word-address width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  SHALL be the reset, synchronous and active-low.
REQ-006 req_read  in  N_REQ  SHALL carry per-requester read strobes, held while waitrequest high.
REQ-007 req_address  in  N_REQ*ADDR_W  SHALL carry per-requester word addresses; slice i belongs to requester i.
REQ-008 req_waitrequest  out  N_REQ  SHALL carry per-requester Avalon-MM stall.
REQ-009 req_readdata  out  DATA_W  SHALL be the read data bus, broadcast to all requesters.
REQ-010 pio_address  out  ADDR_W  SHALL drive the switches PIO address, registered.
REQ-011 pio_readdata  in  DATA_W  SHALL be the PIO readdata, valid one cycle after pio_address is presented.

Function
REQ-012 The FSM SHALL have states IDLE, ADDR, DATA.
REQ-013 IDLE: if any req_read bit is set, the arbiter SHALL pick one requester by round-robin, register grant and its address into pio_address, and go to ADDR; otherwise remain IDLE.
REQ-014 ADDR: pio_address SHALL be stable; the next state SHALL be DATA unconditionally.
REQ-015 DATA: req_waitrequest[grant] SHALL be 0 for exactly this cycle; req_readdata SHALL equal pio_readdata; the next state SHALL be IDLE.
REQ-016 In every other cycle and state, all req_waitrequest bits SHALL be 1.
REQ-017 Latency SHALL be fixed: read asserted in IDLE cycle T gives waitrequest low with data in cycle T+2; throughput is one read per 3 cycles.
REQ-018 Round-robin SHALL search from (last_grant+1) mod N_REQ upward with wrap, lowest index after the pointer winning; last_grant SHALL update on each grant.
REQ-019 Any requester with read held continuously SHALL be served within N_REQ grants (3*N_REQ cycles).
REQ-020 Addresses SHALL pass through unmodified; nonzero addresses return whatever the PIO returns (zero).
REQ-021 If the granted requester drops req_read during ADDR or DATA, the transaction SHALL still complete with no state change other than the normal one; the data is ignored.
REQ-022 Requests newly asserted during ADDR or DATA SHALL be considered only at the next IDLE.
REQ-023 req_address of non-granted requesters SHALL have no effect on pio_address.
REQ-024 pio_address SHALL hold its last value while IDLE with no request.

Reset
REQ-025 With reset_n low at a rising edge: state SHALL become IDLE, pio_address 0, last_grant N_REQ-1 (requester 0 highest priority), all req_waitrequest 1.
REQ-026 A reset in ADDR or DATA SHALL abort the transaction with no waitrequest-low pulse.
REQ-027 req_readdata SHALL be combinational from pio_readdata and needs no reset value.

Structure
REQ-028 Shared package core5_pkg SHALL hold the state enum (IDLE, ADDR, DATA) and the N_REQ/DATA_W/ADDR_W defaults.
REQ-029 Round-robin selection SHALL be one combinational sub-module core5_rr_picker (inputs: request vector, last_grant; outputs: grant index, any-valid).
REQ-030 The FSM, grant/last_grant and pio_address registers SHALL live in core5_switch_arbiter.

Verification
REQ-031 Single read: after reset, req_read=00001, address 0, pio_readdata=0x0002A5C3 -> waitrequest[0] low exactly in cycle T+2 with readdata 0x0002A5C3, all others high.
REQ-032 All five request together from reset and hold -> grant order 0,1,2,3,4,0, one grant per 3 cycles.
REQ-033 Requesters 1 and 3 contend after last_grant=1 -> 3 served first, then 1.
REQ-034 Requester 2 reads address 1 while 4 reads address 0 -> pio_address shows 1 in 2's ADDR cycle and 0 in 4's; 2 receives 0.
REQ-035 reset_n low during ADDR of a grant to requester 0 -> no waitrequest-low pulse, IDLE next cycle, requester 0 regranted first after release.
REQ-036 Requester 0 drops read during ADDR -> DATA cycle still occurs, then IDLE; the next grant goes to a pending requester per round-robin.
